add_cnt_sched: RTL

- Shared statistics-counter scheduler. NUM_REQ requesters post byte/event increments; a round-robin arbiter serialises them into one read-modify-write adder over a bank of wide counters.
- A management port does indexed read or read-and-clear.
- An init sweep zeroes the bank after reset or on request.
- Sits between per-port packet parsers and the CPU register block, replacing one private accumulator per port.

---
 rtl/add_cnt_pkg.sv | 23 ++
 rtl/rr_arb.sv | 32 +++
 rtl/add_cnt_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/add_cnt_pkg.sv
// Shared types and helpers for the statistics-counter scheduler.
package add_cnt_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_ADD_IN_WIDTH = 8;
    localparam int unsigned DEF_ADD_OT_WIDTH = 64;

    // Widest counter the zero-extension helper can serve.
    localparam int unsigned ZEXT_MAX = 128;

    function automatic logic [ZEXT_MAX-1:0] zext_inc(input logic [ZEXT_MAX-1:0] inc,
                                                     input int unsigned         in_w);
        logic [ZEXT_MAX-1:0] mask;
        mask = (in_w >= ZEXT_MAX) ? '1 : ((ZEXT_MAX'(1) << in_w) - ZEXT_MAX'(1));
        return inc & mask;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// searching circularly; next_ptr points one past the winner.
module rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] next_ptr
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = PW'((int'(ptr) + k) % int'(N));
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                next_ptr = PW'((int'(idx) + 1) % int'(N));
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_cnt_sched.sv
// Shared statistics counters: round-robin serialised increments into one RMW
// adder, plus an indexed read / read-and-clear management port.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | sweep writes one counter to zero per cycle, ports stalled
//   ST_RUN  | grants feed the adder stage, management reads accepted
module add_cnt_sched
    import add_cnt_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned ADD_IN_WIDTH = DEF_ADD_IN_WIDTH,
    parameter int unsigned ADD_OT_WIDTH = DEF_ADD_OT_WIDTH,
    parameter int unsigned IDX_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr_all,
    input  logic [NUM_REQ-1:0]              req_vld,
    input  logic [NUM_REQ*ADD_IN_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_rdy,
    input  logic                            rd_req,
    input  logic [IDX_WIDTH-1:0]            rd_idx,
    input  logic                            rd_clr,
    output logic                            rd_rdy,
    output logic                            rd_ack,
    output logic [ADD_OT_WIDTH-1:0]         rd_data,
    output logic                            init_busy
);

    state_e                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    sweep_q, sweep_d;
    logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;
    logic                    s1_vld_q, s1_vld_d;
    logic [IDX_WIDTH-1:0]    s1_idx_q, s1_idx_d;
    logic [ADD_IN_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [IDX_WIDTH-1:0]    rd_idx_q, rd_idx_d;
    logic                    rd_clr_q, rd_clr_d;
    logic                    rd_ack_q, rd_ack_d;
    logic [ADD_OT_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [ADD_OT_WIDTH-1:0] cnt_q [NUM_REQ];
    logic                    cnt_we;
    logic [IDX_WIDTH-1:0]    cnt_widx;
    logic [ADD_OT_WIDTH-1:0] cnt_wdata;

    logic                    rd_accept;
    logic                    arb_en;
    logic [NUM_REQ-1:0]      gnt;
    logic [IDX_WIDTH-1:0]    gnt_idx;
    logic [IDX_WIDTH-1:0]    arb_next_ptr;

    // The accept cycle carries no grant so the read slot finds stage 1 empty.
    assign rd_rdy    = (state_q == ST_RUN) && !rd_pend_q;
    assign rd_accept = rd_req && rd_rdy && !clr_all;
    assign arb_en    = (state_q == ST_RUN) && !clr_all && !rd_accept;

    rr_arb #(
        .N  (NUM_REQ),
        .PW (IDX_WIDTH)
    ) u_arb (
        .req      (req_vld),
        .ptr      (ptr_q),
        .en       (arb_en),
        .gnt      (gnt),
        .next_ptr (arb_next_ptr)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) gnt_idx = IDX_WIDTH'(i);
        end
    end

    assign req_rdy   = gnt;
    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign init_busy = (state_q == ST_INIT);

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        ptr_d     = ptr_q;
        s1_vld_d  = 1'b0;
        s1_idx_d  = s1_idx_q;
        s1_data_d = s1_data_q;
        rd_pend_d = rd_pend_q;
        rd_idx_d  = rd_idx_q;
        rd_clr_d  = rd_clr_q;
        rd_ack_d  = 1'b0;
        rd_data_d = rd_data_q;
        cnt_we    = 1'b0;
        cnt_widx  = s1_idx_q;
        cnt_wdata = cnt_q[s1_idx_q]
                  + ADD_OT_WIDTH'(zext_inc(ZEXT_MAX'(s1_data_q), ADD_IN_WIDTH));

        case (state_q)
            ST_INIT: begin
                cnt_we    = 1'b1;
                cnt_widx  = sweep_q;
                cnt_wdata = '0;
                if (clr_all) begin
                    sweep_d = '0;
                end else if (sweep_q == IDX_WIDTH'(NUM_REQ - 1)) begin
                    sweep_d = '0;
                    state_d = ST_RUN;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_all) begin
                    // Stage 1 is dropped; a pending read still gets its ack.
                    state_d = ST_INIT;
                    sweep_d = '0;
                    if (rd_pend_q) begin
                        rd_ack_d  = 1'b1;
                        rd_data_d = '0;
                        rd_pend_d = 1'b0;
                    end
                end else begin
                    cnt_we = s1_vld_q;
                    if (rd_pend_q) begin
                        rd_data_d = cnt_q[rd_idx_q];
                        rd_ack_d  = 1'b1;
                        rd_pend_d = 1'b0;
                        if (rd_clr_q) begin
                            cnt_we    = 1'b1;
                            cnt_widx  = rd_idx_q;
                            cnt_wdata = '0;
                        end
                    end
                    if (rd_accept) begin
                        rd_pend_d = 1'b1;
                        rd_idx_d  = rd_idx;
                        rd_clr_d  = rd_clr;
                    end
                    if (|gnt) begin
                        s1_vld_d  = 1'b1;
                        s1_idx_d  = gnt_idx;
                        s1_data_d = req_data[int'(gnt_idx)*ADD_IN_WIDTH +: ADD_IN_WIDTH];
                        ptr_d     = arb_next_ptr;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            sweep_q   <= '0;
            ptr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_data_q <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            rd_clr_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            ptr_q     <= ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_idx_q  <= s1_idx_d;
            s1_data_q <= s1_data_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
            rd_clr_q  <= rd_clr_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Counter bank has no reset; the init sweep zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n && cnt_we) cnt_q[cnt_widx] <= cnt_wdata;
    end

endmodule
